pop_rpu_nary: RTL and testbench
===============================

// Module: pop_rpu_nary
// PURPOSE
//  Pop-side replenish unit for one level of the SRAM-backed BMW PIFO tree, generalised to K-ary fan-out.
//  On a parent pop it reads the node's K slots, returns the minimum-priority entry upward, and pops the winning child.
//  It then writes the refilled slot back to SRAM, or marks it empty when its subtree is exhausted.
// PARAMETERS
//  PTW   16  priority/payload width; compared field, low bits of each slot value
//  MTW   0   metadata width, carried above PTW, not compared
//  CTW   10  per-slot subtree element count width
//  ADW   20  node address width
//  K     4   fan-out (power of 2, >=2); KW=$clog2(K) localparam; SW=CTW+MTW+PTW slot width
// PORTS
//  i_clk          in   1        clock
//  i_arst_n       in   1        async active-low reset
//  i_pop          in   1        pop request from parent; held until accepted
//  i_my_addr      in   ADW      node address of request; held with i_pop
//  o_ready        out  1        request accepted in cycle where i_pop&o_ready
//  o_pop_vld      out  1        1-cycle pulse: o_pop_data/o_pop_empty valid
//  o_pop_data     out  MTW+PTW  popped value to parent
//  o_pop_empty    out  1        node held no entries; o_pop_data = all-ones
//  o_child_pop    out  1        1-cycle pop command to child level
//  o_child_addr   out  ADW      child node address = (addr<<KW)+idx, truncated to ADW
//  i_child_vld    in   1        child data valid (any cycle after o_child_pop)
//  i_child_data   in   MTW+PTW  child's popped value
//  o_read         out  1        SRAM read; data on i_read_data next cycle
//  o_read_addr    out  ADW      = i_my_addr
//  i_read_data    in   K*SW     slot j at [j*SW+:SW] = {count, meta, prio}
//  o_write        out  1        SRAM write strobe
//  o_write_addr   out  ADW      latched node address
//  o_write_data   out  K*SW     full node image
//  o_fsm          out  2        current state encoding, debug
// BEHAVIOUR
//  Reset (async): fsm=IDLE; addr/idx/slot registers 0; all strobes 0, data outputs 0; o_ready=1.
//  States: IDLE(00) -> CMP(01) -> [WAIT(11)] -> IDLE; o_ready=1 only in IDLE (see CONFIGURATION).
//  IDLE: on i_pop: o_read=1, latch i_my_addr, ->CMP. Else stay; i_pop outside IDLE ignored (parent holds).
//  CMP (T+1): empty slot = prio all-ones. Argmin of prio over non-empty slots; ties -> lowest index.
//   all empty: o_pop_vld=1, o_pop_empty=1, o_pop_data='1; no write, no child pop; ->IDLE.
//   winner count!=0: o_pop_vld=1, o_pop_data=winner value, o_child_pop=1; latch node image+idx; ->WAIT.
//   winner count==0: o_pop_vld=1; o_write=1 with slot := {0, '1}; ->IDLE.
//  WAIT: hold until i_child_vld; that cycle o_write=1, slot := {count-1, i_child_data}, other slots unchanged; ->IDLE.
//  Decrement only when count!=0, so no underflow. Count is never incremented here.
//  Strobes are 1-cycle pulses; o_pop_data/o_child_addr/o_write_data are 0 when the matching strobe is low.
//  i_child_vld outside WAIT: ignored.
//  Reset mid-operation: pending child pop abandoned, no write issued; reset dominates every event.
// CONFIGURATION
//  RPU_FWD_EN defined: o_ready is also 1 in a write cycle. If a pop is accepted that cycle with i_my_addr == write addr,
//   CMP uses the just-written image (forward register) instead of i_read_data. Back-to-back pop interval = write cycle.
//  RPU_FWD_EN undefined: o_ready=0 in the write cycle (the write occurs as the state returns to IDLE), giving one bubble.
//   The next pop is accepted the following cycle; no forward path.
// STRUCTURE
//  rpu_pkg: state enum (IDLE/CMP/WAIT); slot field-offset functions; empty-sentinel function; child-address function.
//  Sub-module rpu_min_sel: K-way combinational argmin tree over prio with empty mask.
//   Outputs idx[KW-1:0] and all_empty; lowest index wins ties.
// TESTING
//  1 K=4, slots prio {9,3,7,5}, counts {1,2,0,0}: pop -> T+1 o_pop_data=3, o_child_addr=4*addr+1; child returns 4 -> slot1={1,4}.
//  2 All slots prio 'hFFFF, count 0: pop -> o_pop_vld=1, o_pop_empty=1, no o_write, no o_child_pop.
//  3 Winner prio 2 with count 0: pop -> data 2, o_write slot={0,'hFFFF}, o_child_pop never asserted.
//  4 Tie prio {6,6,6,8}: winner idx 0; repeat with slot0 empty -> idx 1.
//  5 Two pops to same addr, child vld 3 cycles late: FWD_EN -> 2nd accepted in write cycle, sees refilled slot; else 1-cycle bubble.
//  6 Assert reset in WAIT -> all outputs 0, o_ready=1 next cycle, no write; late i_child_vld ignored.

Source files
------------

// File: rtl/pop_rpu_nary_pkg.sv
// Shared state type and slot-field helpers for the K-ary pop replenish unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pop_rpu_nary_pkg;

   // FSM state; the encodings are visible on the o_fsm debug port
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CMP  = 2'b01,
      ST_WAIT = 2'b11
   } rpu_state_t;

   // Bit offset of slot j inside a node image of sw-bit slots
   function automatic int slot_lsb(input int j, input int sw);
      return j * sw;
   endfunction

   // Bit offset of the count field inside one slot (it sits above meta and prio)
   function automatic int cnt_lsb(input int mtw, input int ptw);
      return mtw + ptw;
   endfunction

   // Empty sentinel: all-ones in the low vw bits (prio all-ones marks an empty slot)
   function automatic logic [63:0] empty_val(input int vw);
      if (vw >= 64)
         return '1;
      return (64'd1 << vw) - 64'd1;
   endfunction

   // Child node address: parent address scaled by the fan-out plus slot index
   function automatic logic [63:0] child_addr(input logic [63:0] addr, input int kw, input int idx);
      return (addr << kw) + 64'(unsigned'(idx));
   endfunction

endpackage

// File: rtl/pop_rpu_nary_min_sel.sv
// K-way argmin over slot priorities with an empty mask; lowest index wins ties.
// Latency: purely combinational.
// Backpressure: none.
module pop_rpu_nary_min_sel
   import pop_rpu_nary_pkg::*;
#(
   parameter int PTW = 16,
   parameter int K   = 4,
   parameter int KW  = $clog2(K)
) (
   input  logic [K*PTW-1:0] prio,
   input  logic [K-1:0]     empty,
   output logic [KW-1:0]    idx,
   output logic             all_empty
);

   // Heap-ordered tree: node n has children 2n and 2n+1, leaves live at K..2K-1
   logic [PTW-1:0] node_prio [1:2*K-1];
   logic [KW-1:0]  node_idx  [1:2*K-1];
   logic           node_vld  [1:2*K-1];

   // Reduce pairwise toward the root; the right child wins only on a strictly smaller prio
   always_comb begin
      for (int n = 1; n < 2*K; n++) begin
         node_prio[n] = '1;
         node_idx[n]  = '0;
         node_vld[n]  = 1'b0;
      end
      for (int j = 0; j < K; j++) begin
         node_prio[K+j] = prio[j*PTW +: PTW];
         node_idx[K+j]  = KW'(j);
         node_vld[K+j]  = !empty[j];
      end
      for (int n = K-1; n >= 1; n--) begin
         if (node_vld[2*n+1] && (!node_vld[2*n] || (node_prio[2*n+1] < node_prio[2*n]))) begin
            node_prio[n] = node_prio[2*n+1];
            node_idx[n]  = node_idx[2*n+1];
            node_vld[n]  = 1'b1;
         end else begin
            node_prio[n] = node_prio[2*n];
            node_idx[n]  = node_idx[2*n];
            node_vld[n]  = node_vld[2*n];
         end
      end
      idx       = node_idx[1];
      all_empty = !node_vld[1];
   end

endmodule

// File: rtl/pop_rpu_nary.sv
// Pop-side replenish unit for one K-ary PIFO tree level: pop min slot upward, refill it from the child.
// Latency: pop result the cycle after acceptance; write-back then, or in the cycle the child answers.
// Backpressure: o_ready only in IDLE (RPU_FWD_EN also accepts in the write cycle, forwarding the image).
module pop_rpu_nary
   import pop_rpu_nary_pkg::*;
#(
   parameter int PTW = 16,
   parameter int MTW = 0,
   parameter int CTW = 10,
   parameter int ADW = 20,
   parameter int K   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_arst_n,
   input  logic                 i_pop,
   input  logic [ADW-1:0]       i_my_addr,
   output logic                 o_ready,
   output logic                 o_pop_vld,
   output logic [MTW+PTW-1:0]   o_pop_data,
   output logic                 o_pop_empty,
   output logic                 o_child_pop,
   output logic [ADW-1:0]       o_child_addr,
   input  logic                 i_child_vld,
   input  logic [MTW+PTW-1:0]   i_child_data,
   output logic                 o_read,
   output logic [ADW-1:0]       o_read_addr,
   input  logic [K*(CTW+MTW+PTW)-1:0] i_read_data,
   output logic                 o_write,
   output logic [ADW-1:0]       o_write_addr,
   output logic [K*(CTW+MTW+PTW)-1:0] o_write_data,
   output logic [1:0]           o_fsm
);

   localparam int KW = $clog2(K);
   localparam int VW = MTW + PTW;
   localparam int SW = CTW + VW;
   localparam int IW = K * SW;

   rpu_state_t      state;
   logic [ADW-1:0]  addr_q;
   logic [KW-1:0]   idx_q;
   logic [IW-1:0]   img_q;

   logic [IW-1:0]   img;
   logic [K*PTW-1:0] prio_flat;
   logic [K-1:0]    empty_mask;
   logic [KW-1:0]   sel_idx;
   logic            all_empty;
   logic [SW-1:0]   win_slot;
   logic [CTW-1:0]  win_cnt;
   logic [VW-1:0]   win_val;
   logic [CTW-1:0]  wait_cnt;
   logic [CTW-1:0]  dec_cnt;
   logic            accept;

`ifdef RPU_FWD_EN
   logic            fwd_q;
   logic [IW-1:0]   fwd_img_q;
`endif

   // Node image seen by CMP: SRAM data, or the image just written when it targeted the same node
   always_comb begin
`ifdef RPU_FWD_EN
      img = fwd_q ? fwd_img_q : i_read_data;
`else
      img = i_read_data;
`endif
   end

   // Split the image into per-slot priorities and empty flags for the argmin
   always_comb begin
      prio_flat  = '0;
      empty_mask = '0;
      for (int j = 0; j < K; j++) begin
         prio_flat[j*PTW +: PTW] = img[slot_lsb(j, SW) +: PTW];
         empty_mask[j]           = &img[slot_lsb(j, SW) +: PTW];
      end
   end

   pop_rpu_nary_min_sel #(
      .PTW (PTW),
      .K   (K),
      .KW  (KW)
   ) u_min_sel (
      .prio      (prio_flat),
      .empty     (empty_mask),
      .idx       (sel_idx),
      .all_empty (all_empty)
   );

   // Winner fields in CMP, and the saturating decrement of the latched winner's count in WAIT
   always_comb begin
      win_slot = img[slot_lsb(int'(sel_idx), SW) +: SW];
      win_cnt  = win_slot[cnt_lsb(MTW, PTW) +: CTW];
      win_val  = win_slot[VW-1:0];
      wait_cnt = img_q[slot_lsb(int'(idx_q), SW) + cnt_lsb(MTW, PTW) +: CTW];
      dec_cnt  = (wait_cnt != '0) ? (wait_cnt - CTW'(1)) : wait_cnt;
   end

   // Outputs decode straight from state and the arriving SRAM/child data so each strobe lands
   // in the cycle its data is available; every data bus is zero while its strobe is low
   always_comb begin
      o_ready      = (state == ST_IDLE);
      o_pop_vld    = 1'b0;
      o_pop_data   = '0;
      o_pop_empty  = 1'b0;
      o_child_pop  = 1'b0;
      o_child_addr = '0;
      o_write      = 1'b0;
      o_write_addr = '0;
      o_write_data = '0;
      o_read       = 1'b0;
      o_read_addr  = '0;
      accept       = 1'b0;
      case (state)
         ST_CMP: begin
            o_pop_vld = 1'b1;
            if (all_empty) begin
               o_pop_empty = 1'b1;
               o_pop_data  = VW'(empty_val(VW));
            end else begin
               o_pop_data = win_val;
               if (win_cnt != '0) begin
                  o_child_pop  = 1'b1;
                  o_child_addr = ADW'(child_addr(64'(addr_q), KW, int'(sel_idx)));
               end else begin
                  o_write      = 1'b1;
                  o_write_addr = addr_q;
                  o_write_data = img;
                  o_write_data[slot_lsb(int'(sel_idx), SW) +: SW] = {CTW'(0), VW'(empty_val(VW))};
               end
            end
         end
         ST_WAIT: begin
            if (i_child_vld) begin
               o_write      = 1'b1;
               o_write_addr = addr_q;
               o_write_data = img_q;
               o_write_data[slot_lsb(int'(idx_q), SW) +: SW] = {dec_cnt, i_child_data};
            end
         end
         default: ;
      endcase
`ifdef RPU_FWD_EN
      if (o_write)
         o_ready = 1'b1;
`endif
      accept = i_pop && o_ready;
      if (accept) begin
         o_read      = 1'b1;
         o_read_addr = i_my_addr;
      end
   end

   // FSM and datapath registers; a newly accepted pop always steers the next state to CMP
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         idx_q  <= '0;
         img_q  <= '0;
`ifdef RPU_FWD_EN
         fwd_q     <= 1'b0;
         fwd_img_q <= '0;
`endif
      end else begin
         case (state)
            ST_CMP: begin
               if (!all_empty && (win_cnt != '0)) begin
                  img_q <= img;
                  idx_q <= sel_idx;
                  state <= ST_WAIT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (i_child_vld)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (accept) begin
            state  <= ST_CMP;
            addr_q <= i_my_addr;
`ifdef RPU_FWD_EN
            fwd_q     <= o_write && (i_my_addr == addr_q);
            fwd_img_q <= o_write_data;
`endif
         end
      end
   end

   assign o_fsm = state;

endmodule

// File: tb/tb_pop_rpu_nary.sv
// Bench for pop_rpu_nary: directed pops against a slot-level model, per-cycle output compare.
// Latency: n/a.
// Backpressure: pops are held until o_ready; child responses come after a programmable delay.
module tb_pop_rpu_nary;

   localparam int PTW = 16;
   localparam int MTW = 0;
   localparam int CTW = 10;
   localparam int ADW = 20;
   localparam int K   = 4;
   localparam int VW  = MTW + PTW;
   localparam int SW  = CTW + VW;
   localparam int IW  = K * SW;
`ifdef RPU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            i_clk = 1'b0;
   logic            i_arst_n = 1'b0;
   logic            i_pop = 1'b0;
   logic [ADW-1:0]  i_my_addr = '0;
   logic            o_ready;
   logic            o_pop_vld;
   logic [VW-1:0]   o_pop_data;
   logic            o_pop_empty;
   logic            o_child_pop;
   logic [ADW-1:0]  o_child_addr;
   logic            i_child_vld = 1'b0;
   logic [VW-1:0]   i_child_data = '0;
   logic            o_read;
   logic [ADW-1:0]  o_read_addr;
   logic [IW-1:0]   i_read_data = '0;
   logic            o_write;
   logic [ADW-1:0]  o_write_addr;
   logic [IW-1:0]   o_write_data;
   logic [1:0]      o_fsm;

   pop_rpu_nary #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .K(K)) dut (
      .i_clk(i_clk), .i_arst_n(i_arst_n), .i_pop(i_pop), .i_my_addr(i_my_addr),
      .o_ready(o_ready), .o_pop_vld(o_pop_vld), .o_pop_data(o_pop_data), .o_pop_empty(o_pop_empty),
      .o_child_pop(o_child_pop), .o_child_addr(o_child_addr), .i_child_vld(i_child_vld),
      .i_child_data(i_child_data), .o_read(o_read), .o_read_addr(o_read_addr),
      .i_read_data(i_read_data), .o_write(o_write), .o_write_addr(o_write_addr),
      .o_write_data(o_write_data), .o_fsm(o_fsm)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_wr = 0;
   int n_cp = 0;
   int last_wr_cyc = -100;
   int last_gap = -1;
   int child_delay = 1;
   logic [VW-1:0]  child_val = '0;
   logic [ADW-1:0] last_child_addr = '0;
   logic [VW-1:0]  last_pop_data = '0;
   logic           last_pop_empty = 1'b0;

   // Model: per-slot priority and count, keyed by addr*K+slot
   int mprio[int];
   int mcnt[int];
   // Environment SRAM, written only by the DUT's write port
   logic [IW-1:0] sram[int];

   task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [IW-1:0] mk_img(input int p0, p1, p2, p3, c0, c1, c2, c3);
      int p[4];
      int c[4];
      logic [IW-1:0] r;
      p = '{p0, p1, p2, p3};
      c = '{c0, c1, c2, c3};
      r = '0;
      for (int j = 0; j < K; j++)
         r[j*SW +: SW] = {c[j][CTW-1:0], p[j][PTW-1:0]};
      return r;
   endfunction

   function automatic logic [IW-1:0] model_img(input int a);
      logic [IW-1:0] r;
      r = '0;
      for (int j = 0; j < K; j++)
         r[j*SW +: SW] = {mcnt[a*K+j][CTW-1:0], mprio[a*K+j][PTW-1:0]};
      return r;
   endfunction

   task automatic load(input int a, input int p0, p1, p2, p3, c0, c1, c2, c3);
      sram[a] = mk_img(p0, p1, p2, p3, c0, c1, c2, c3);
      mprio[a*K+0] = p0; mprio[a*K+1] = p1; mprio[a*K+2] = p2; mprio[a*K+3] = p3;
      mcnt[a*K+0]  = c0; mcnt[a*K+1]  = c1; mcnt[a*K+2]  = c2; mcnt[a*K+3]  = c3;
   endtask

   // Called just after a posedge; returns just after the accepting posedge
   task automatic do_pop(input int a);
      i_pop = 1'b1;
      i_my_addr = ADW'(a);
      for (int k = 0; k < 40; k++) begin
         @(negedge i_clk);
         if (o_ready) begin
            @(posedge i_clk);
            #1;
            i_pop = 1'b0;
            i_my_addr = '0;
            return;
         end
      end
      n_chk++;
      n_fail++;
      $display("FAIL pop_accept_timeout addr %0d: not accepted, required within 40 cycles", a);
      i_pop = 1'b0;
      i_my_addr = '0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // SRAM: read returns the pre-write contents; data lands just after the edge
   initial begin : sram_model
      bit rd, wr;
      int ra, wa;
      logic [IW-1:0] wd;
      forever begin
         @(negedge i_clk);
         rd = o_read;
         ra = int'(o_read_addr);
         wr = o_write && i_arst_n;
         wa = int'(o_write_addr);
         wd = o_write_data;
         @(posedge i_clk);
         #1;
         if (rd) i_read_data = sram.exists(ra) ? sram[ra] : '0;
         if (wr) sram[wa] = wd;
      end
   end

   // Child level: answers each child pop after child_delay cycles with child_val
   initial begin : child_model
      forever begin
         @(negedge i_clk);
         if (o_child_pop && i_arst_n) begin
            last_child_addr = o_child_addr;
            repeat (child_delay) @(posedge i_clk);
            #1;
            i_child_vld = 1'b1;
            i_child_data = child_val;
            @(posedge i_clk);
            #1;
            i_child_vld = 1'b0;
            i_child_data = '0;
         end
      end
   end

   // Per-cycle compare of every DUT output against the slot-level model
   initial begin : compare
      bit acc_flag, exp_pop, waiting, exp_wr, exp_rdy;
      int cur_addr, pend_addr, widx, best, key;
      acc_flag = 0; waiting = 0; cur_addr = 0; pend_addr = 0; widx = 0;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (o_write) n_wr++;
         if (o_child_pop) n_cp++;
         if (!i_arst_n) begin
            chk("rst_ready", o_ready, 1);
            chk("rst_strobes", {o_pop_vld, o_pop_empty, o_child_pop, o_write}, 0);
            chk("rst_data", {o_pop_data, o_child_addr, o_write_addr}, 0);
            chk("rst_wdata", o_write_data, 0);
            chk("rst_fsm", o_fsm, 0);
            acc_flag = 0;
            waiting = 0;
         end else begin
            exp_pop = acc_flag;
            if (acc_flag) cur_addr = pend_addr;
            acc_flag = 0;
            exp_wr = 0;
            exp_rdy = !(exp_pop || waiting);
            chk("fsm", o_fsm, exp_pop ? 2'b01 : (waiting ? 2'b11 : 2'b00));
            if (waiting && i_child_vld) begin
               key = cur_addr*K + widx;
               mprio[key] = int'(i_child_data);
               if (mcnt[key] != 0) mcnt[key]--;
               waiting = 0;
               exp_wr = 1;
            end
            chk("pop_vld", o_pop_vld, exp_pop);
            if (exp_pop) begin
               best = -1;
               for (int j = 0; j < K; j++)
                  if (mprio[cur_addr*K+j] != 'hFFFF &&
                      (best < 0 || mprio[cur_addr*K+j] < mprio[cur_addr*K+best]))
                     best = j;
               if (best < 0) begin
                  chk("pop_empty", o_pop_empty, 1);
                  chk("pop_data_empty", o_pop_data, 'hFFFF);
                  chk("child_pop", o_child_pop, 0);
               end else begin
                  key = cur_addr*K + best;
                  chk("pop_empty", o_pop_empty, 0);
                  chk("pop_data", o_pop_data, mprio[key]);
                  if (mcnt[key] != 0) begin
                     chk("child_pop", o_child_pop, 1);
                     chk("child_addr", o_child_addr, (cur_addr*K + best) % (1 << ADW));
                     waiting = 1;
                     widx = best;
                  end else begin
                     chk("child_pop", o_child_pop, 0);
                     mprio[key] = 'hFFFF;
                     exp_wr = 1;
                  end
               end
               last_pop_data = o_pop_data;
               last_pop_empty = o_pop_empty;
            end else begin
               chk("pop_idle", {o_pop_empty, o_child_pop, o_pop_data}, 0);
            end
            if (!o_child_pop) chk("child_addr_zero", o_child_addr, 0);
            chk("write", o_write, exp_wr);
            if (exp_wr) begin
               chk("write_addr", o_write_addr, cur_addr);
               chk("write_data", o_write_data, model_img(cur_addr));
               last_wr_cyc = cyc;
            end else begin
               chk("write_zero", {o_write_addr, o_write_data}, 0);
            end
            if (FWD && exp_wr) exp_rdy = 1;
            chk("ready", o_ready, exp_rdy);
            chk("read", o_read, i_pop && exp_rdy);
            if (i_pop && exp_rdy) begin
               chk("read_addr", o_read_addr, i_my_addr);
               acc_flag = 1;
               pend_addr = int'(i_my_addr);
               last_gap = cyc - last_wr_cyc;
            end else begin
               chk("read_addr_zero", o_read_addr, 0);
            end
         end
      end
   end

   // Directed scenarios with hand-computed expectations
   initial begin : stim
      int w0, c0;
      repeat (2) @(negedge i_clk);
      @(posedge i_clk); #1;
      i_arst_n = 1'b1;
      settle(1);

      // Min prio 3 at slot 1 with count 2; child refills it with 4
      load(5, 9, 3, 7, 5, 1, 2, 0, 0);
      child_delay = 1; child_val = 16'd4;
      do_pop(5); settle(8);
      chk("t1_pop_data", last_pop_data, 3);
      chk("t1_child_addr", last_child_addr, 21);
      chk("t1_image", sram[5], mk_img(9, 4, 7, 5, 1, 1, 0, 0));

      // Fully empty node
      load(7, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 0, 0, 0, 0);
      w0 = n_wr; c0 = n_cp;
      do_pop(7); settle(6);
      chk("t2_empty", last_pop_empty, 1);
      chk("t2_data", last_pop_data, 'hFFFF);
      chk("t2_no_write", n_wr - w0, 0);
      chk("t2_no_child", n_cp - c0, 0);

      // Winner with an exhausted subtree is drained in place
      load(9, 'hFFFF, 2, 'hFFFF, 10, 0, 0, 0, 3);
      w0 = n_wr; c0 = n_cp;
      do_pop(9); settle(6);
      chk("t3_data", last_pop_data, 2);
      chk("t3_image", sram[9], mk_img('hFFFF, 'hFFFF, 'hFFFF, 10, 0, 0, 0, 3));
      chk("t3_one_write", n_wr - w0, 1);
      chk("t3_no_child", n_cp - c0, 0);

      // Three-way tie picks slot 0, then slot 1 once slot 0 is empty
      load(11, 6, 6, 6, 8, 1, 1, 1, 1);
      child_val = 16'd20;
      do_pop(11); settle(8);
      chk("t4a_child_addr", last_child_addr, 44);
      chk("t4a_image", sram[11], mk_img(20, 6, 6, 8, 0, 1, 1, 1));
      load(12, 'hFFFF, 6, 6, 8, 0, 1, 1, 1);
      child_val = 16'd30;
      do_pop(12); settle(8);
      chk("t4b_child_addr", last_child_addr, 49);
      chk("t4b_image", sram[12], mk_img('hFFFF, 30, 6, 8, 0, 0, 1, 1));

      // Back-to-back pops to one node with a slow child; second sees the refilled slot 0
      load(13, 4, 8, 9, 10, 3, 0, 0, 0);
      child_delay = 3; child_val = 16'd12;
      do_pop(13);
      do_pop(13);
      settle(8);
      chk("t5_second_data", last_pop_data, 8);
      chk("t5_gap", last_gap, FWD ? 0 : 1);
      chk("t5_image", sram[13], mk_img(12, 'hFFFF, 9, 10, 2, 0, 0, 0));

      // Reset while waiting on the child: no write, late child answer ignored
      load(15, 5, 6, 7, 8, 2, 1, 1, 1);
      child_delay = 8; child_val = 16'd99;
      w0 = n_wr;
      do_pop(15);
      settle(2);
      i_arst_n = 1'b0;
      settle(1);
      i_arst_n = 1'b1;
      @(negedge i_clk);
      chk("t6_ready", o_ready, 1);
      chk("t6_fsm", o_fsm, 0);
      settle(12);
      chk("t6_no_write", n_wr - w0, 0);
      chk("t6_image", sram[15], mk_img(5, 6, 7, 8, 2, 1, 1, 1));

      // Normal operation resumes after the reset
      child_delay = 1; child_val = 16'd1;
      do_pop(15); settle(8);
      chk("t7_data", last_pop_data, 5);
      chk("t7_image", sram[15], mk_img(1, 6, 7, 8, 1, 1, 1, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
